// File: rtl/result_stream_reader.sv
// Snapshots two unpacked result arrays on start and streams them out
// interleaved (x0, y0, x1, y1, ...) over a registered valid/ready port.
module result_stream_reader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_an,
    input  logic [WIDTH-1:0]                  result_x [0:DEPTH-1],
    input  logic [WIDTH-1:0]                  result_y [0:DEPTH-1],
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic [WIDTH-1:0]                  out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_last,
    output logic [$clog2(2*DEPTH)-1:0]        out_index
);

    localparam int IW = $clog2(2*DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(2*DEPTH-1);

    localparam logic IDLE = 1'b0;
    localparam logic SEND = 1'b1;

    logic                state;
    logic [IW-1:0]       idx;
    logic [WIDTH-1:0]    snap_x [0:DEPTH-1];
    logic [WIDTH-1:0]    snap_y [0:DEPTH-1];

    logic [IW-1:0]       nxt_idx;
    logic [WIDTH-1:0]    nxt_word;

    // Next word is precomputed so out_data can be loaded on the handshake edge.
    always_comb begin
        nxt_idx  = idx + IW'(1);
        nxt_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((nxt_idx >> 1) == IW'(i)) begin
                nxt_word = nxt_idx[0] ? snap_y[i] : snap_x[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            state     <= IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                snap_x[i] <= '0;
                snap_y[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            snap_x[i] <= result_x[i];
                            snap_y[i] <= result_y[i];
                        end
                        state     <= SEND;
                        idx       <= '0;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        out_data  <= result_x[0];
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            idx      <= nxt_idx;
                            out_data <= nxt_word;
                            out_last <= (nxt_idx == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_index = idx;

endmodule

// File: tb/tb_result_stream_reader.sv
// Directed bench for result_stream_reader: reset, basic stream, backpressure,
// snapshot isolation, back-to-back start and mid-stream reset.
module tb_result_stream_reader;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int NW    = 2*DEPTH;

    logic              clk = 1'b0;
    logic              rst_an;
    logic [WIDTH-1:0]  result_x [0:DEPTH-1];
    logic [WIDTH-1:0]  result_y [0:DEPTH-1];
    logic              start;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [2:0]        out_index;

    logic [31:0]       exp_w [0:NW-1];
    int                checks = 0;
    int                errors = 0;

    result_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_an    (rst_an),
        .result_x  (result_x),
        .result_y  (result_y),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_index (out_index)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // x[i] = bx + i*sx, y[i] = by + i*sy; expected stream interleaves them
    task automatic load_arrays(input logic [31:0] bx, input logic [31:0] sx,
                               input logic [31:0] by, input logic [31:0] sy);
        for (int i = 0; i < DEPTH; i++) begin
            result_x[i]   = bx + 32'(i) * sx;
            result_y[i]   = by + 32'(i) * sy;
            exp_w[2*i]    = result_x[i];
            exp_w[2*i+1]  = result_y[i];
        end
    endtask

    // Called at the negedge just after start acceptance. Returns at the negedge
    // where done should be visible (or early when stop_k < NW).
    task automatic drain(input bit bp, input int start_at, input int stop_k);
        logic [15:0] pat;
        int k;
        int cyc;
        bit rdy;
        pat = 16'b1011_0010_0110_1001;
        k = 0;
        cyc = 0;
        while (k < stop_k && cyc < 200) begin
            check("valid", 32'(out_valid), 32'd1);
            check("busy",  32'(busy), 32'd1);
            check("data",  out_data, exp_w[k]);
            check("index", 32'(out_index), 32'(k));
            check("last",  32'(out_last), 32'(k == NW-1));
            check("done_mid", 32'(done), 32'd0);
            rdy = bp ? pat[cyc % 16] : 1'b1;
            out_ready = rdy;
            start = (cyc == start_at);
            @(negedge clk);
            if (rdy) k++;
            cyc++;
        end
        start = 1'b0;
        if (cyc >= 200) check("timeout", 32'd0, 32'd1);
        if (stop_k >= NW) begin
            check("done_pulse", 32'(done), 32'd1);
            check("valid_end",  32'(out_valid), 32'd0);
            check("busy_end",   32'(busy), 32'd0);
        end
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        rst_an    = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        load_arrays(32'h0, 32'h0, 32'h0, 32'h0);

        // Reset with random inputs
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < DEPTH; i++) begin
                result_x[i] = $urandom;
                result_y[i] = $urandom;
            end
            start     = 1'($urandom);
            out_ready = 1'($urandom);
            @(negedge clk);
        end
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_last",  32'(out_last), 32'd0);
        check("rst_index", 32'(out_index), 32'd0);
        check("rst_data",  out_data, 32'd0);
        start     = 1'b0;
        out_ready = 1'b1;
        rst_an    = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle_busy",  32'(busy), 32'd0);
            check("idle_valid", 32'(out_valid), 32'd0);
        end

        // Basic stream
        load_arrays(32'h11111111, 32'h11111111, 32'h0000000A, 32'h1);
        pulse_start();
        drain(1'b0, -1, NW);
        @(negedge clk);
        check("done_once", 32'(done), 32'd0);

        // Backpressure
        load_arrays(32'h11111111, 32'h11111111, 32'h0000000A, 32'h1);
        pulse_start();
        drain(1'b1, -1, NW);
        @(negedge clk);
        check("bp_done_once", 32'(done), 32'd0);

        // Snapshot isolation with an ignored mid-stream start
        load_arrays(32'h5A5A0000, 32'h00000101, 32'hA5A50000, 32'h00000202);
        pulse_start();
        for (int i = 0; i < DEPTH; i++) begin
            result_x[i] = 32'hFFFFFFFF;
            result_y[i] = 32'hFFFFFFFF;
        end
        drain(1'b0, 3, NW);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("iso_no_done",  32'(done), 32'd0);
            check("iso_no_valid", 32'(out_valid), 32'd0);
        end

        // Back-to-back: start issued in the done cycle
        load_arrays(32'h12340000, 32'h1, 32'h56780000, 32'h1);
        pulse_start();
        drain(1'b0, -1, NW);
        load_arrays(32'hC0DE0000, 32'h10, 32'hBEEF0000, 32'h10);
        pulse_start();
        check("b2b_x0", out_data, 32'hC0DE0000);
        drain(1'b0, -1, NW);
        @(negedge clk);
        check("b2b_done_once", 32'(done), 32'd0);

        // Reset after word 3 is accepted
        load_arrays(32'h00010000, 32'h1, 32'h00020000, 32'h1);
        pulse_start();
        drain(1'b0, -1, 4);
        rst_an = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy",  32'(busy), 32'd0);
        check("mid_rst_data",  out_data, 32'd0);
        check("mid_rst_index", 32'(out_index), 32'd0);
        @(negedge clk);
        check("mid_rst_done", 32'(done), 32'd0);
        rst_an = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_rst_done",  32'(done), 32'd0);
            check("post_rst_valid", 32'(out_valid), 32'd0);
        end
        load_arrays(32'h77770000, 32'h3, 32'h88880000, 32'h5);
        pulse_start();
        drain(1'b1, -1, NW);
        @(negedge clk);
        check("final_done_once", 32'(done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_stream_reader.md
# result_stream_reader

Drains the two unpacked result arrays (`result_x[0:DEPTH-1]`, `result_y[0:DEPTH-1]`) that a multi-unpacked-port compute block produces, and serialises them onto a single valid/ready word stream. The block snapshots both arrays on a start request and then emits them interleaved: x0, y0, x1, y1, and so on. It sits between the array-producing datapath and a narrow downstream consumer such as a bus bridge or a monitor FIFO.

## Interface
- `WIDTH`, default 32: bit width of each array element and of `out_data`.
- `DEPTH`, default 4: number of entries in each unpacked input array; legal range ≥1.
- `clk`  input  1  sole clock; all logic is on the rising edge.
- `rst_an`  input  1  asynchronous reset, active-low. This is the only reset.
- `result_x`  input  [WIDTH-1:0] x [0:DEPTH-1]  first result array; sampled only at start acceptance.
- `result_y`  input  [WIDTH-1:0] x [0:DEPTH-1]  second result array; sampled only at start acceptance.
- `start`  input  1  single-cycle or level request to snapshot and stream.
- `busy`  output  1  high from the cycle after start acceptance until the final handshake cycle, inclusive.
- `done`  output  1  one-cycle pulse in the cycle after the final handshake.
- `out_data`  output  [WIDTH-1:0]  current stream word.
- `out_valid`  output  1  `out_data` is valid.
- `out_ready`  input  1  consumer accepts the word when `out_valid` and `out_ready` are both high.
- `out_last`  output  1  marks the final word (y[DEPTH-1]).
- `out_index`  output  [$clog2(2*DEPTH)-1:0]  position of the current word in the stream, 0..2*DEPTH-1.

## Operation
- **State machine:** IDLE and SEND.
- **IDLE:**
  - `busy` = 0 and `out_valid` = 0.
  - If `start` = 1, copy `result_x` and `result_y` into internal unpacked snapshot registers, clear the index, and go to SEND.
- **SEND:**
  - `out_valid` = 1.
  - `out_data` = snap_x[idx>>1] when idx is even, snap_y[idx>>1] when idx is odd.
  - `out_index` = idx.
  - `out_last` = (idx == 2*DEPTH-1).
  - On a handshake with `out_last` = 0: idx increments.
  - On a handshake with `out_last` = 1: go to IDLE and assert `done` in the next cycle.
- **Start handling:**
  - `start` is ignored while in SEND; there is no queueing and no restart.
  - A start in the same cycle as the `done` pulse is accepted, because the block is in IDLE then.
- **Stability:**
  - While `out_valid` = 1 and `out_ready` = 0, `out_data`, `out_index` and `out_last` hold stable.
  - `out_valid` never drops before its handshake.
- **Input isolation:** changes on `result_x`/`result_y` after start acceptance have no effect on the current stream.
- **Arithmetic:**
  - No arithmetic is done on data; words pass through bit-exact.
  - idx is an unsigned counter of $clog2(2*DEPTH) bits. It never wraps, because it is cleared at start acceptance.
- **Reset:**
  - Asserting `rst_an` forces IDLE, idx = 0, `busy` = 0, `done` = 0, `out_valid` = 0, `out_last` = 0, `out_index` = 0 and `out_data` = 0.
  - Snapshot registers clear to 0.
  - Reset mid-stream abandons the stream with no `done` pulse.
  - The first `start` after reset release is honoured normally.

## Timing
- Start accepted at edge N → `out_valid` = 1, `busy` = 1 and word 0 are present after edge N.
- With `out_ready` held at 1, one word transfers per cycle, so the stream takes 2*DEPTH cycles.
- Final handshake at edge M → after edge M, `out_valid` = 0, `busy` = 0 and `done` = 1 for exactly one cycle.
- Start-to-`done` minimum is 2*DEPTH+1 edges.
- All outputs are registered; there is no combinational path from `out_ready` or `start` to any output.
- `out_ready` may be high in IDLE; it is ignored there.

## Test plan
- **Reset values:** hold `rst_an` = 0 with random inputs → all outputs are 0. Release, with `start` held 0 for 10 cycles → `busy` stays 0 and `out_valid` stays 0.
- **Basic stream:**
  - Setup: DEPTH = 4, x = {0x11111111, 0x22222222, 0x33333333, 0x44444444}, y = {0xA, 0xB, 0xC, 0xD}, `out_ready` = 1, one-cycle `start`.
  - Required: words 0x11111111, 0xA, 0x22222222, 0xB, 0x33333333, 0xC, 0x44444444, 0xD on 8 consecutive cycles.
  - Required: `out_index` runs 0..7 and `out_last` is high only on 0xD.
  - Required: `done` pulses one cycle after 0xD.
- **Backpressure:** toggle `out_ready` pseudo-randomly → identical 8-word sequence, with `out_data`, `out_index` and `out_last` stable across every stalled cycle.
- **Snapshot isolation and ignored start:**
  - Stimulus: after start acceptance, change all inputs to 0xFFFFFFFF and pulse `start` again mid-stream.
  - Required: the original values are streamed, there is exactly one `done`, and no second stream follows.
- **Back-to-back:** assert `start` in the `done` cycle with new arrays → the second stream begins the next cycle with the new x0.
- **Reset mid-operation:** assert `rst_an` low after word 3 is accepted → `out_valid` drops immediately, no `done` pulse. A subsequent start streams from index 0.
